// File: rtl/su_pkg.sv
// Shared store-unit definitions: store type codes, the AdES exception code, and the
// byte-enable / lane-replication formatter used at store acceptance.
package su_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_type_e;

  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_fmt_t;

  // Byte enables and lane-replicated write data for a right-justified store operand.
  function automatic st_fmt_t format_store(input logic [1:0]  st_type,
                                           input logic [1:0]  k,
                                           input logic [31:0] data);
    st_fmt_t f;
    f.be    = 4'b0000;
    f.wdata = 32'h0000_0000;
    case (st_type_e'(st_type))
      ST_SW: begin
        f.be    = 4'b1111;
        f.wdata = data;
      end
      ST_SH: begin
        f.be    = k[1] ? 4'b1100 : 4'b0011;
        f.wdata = {2{data[15:0]}};
      end
      ST_SB: begin
        f.be    = 4'b0001 << k;
        f.wdata = {4{data[7:0]}};
      end
      default: begin
        f.be    = 4'b0000;
        f.wdata = 32'h0000_0000;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/su_fifo.sv
// Store queue: DEPTH-entry FIFO with registered pointers and occupancy count.
// No bypass: a pop in the same cycle never frees a slot for a push.
module su_fifo #(
  parameter int  DEPTH = 2,
  parameter int  W     = 66,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;

  // Queue storage, pointers and occupancy; reset drops every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;

endmodule

// File: rtl/store_unit.sv
// M-stage store formatter and store queue draining to the bridge over req/ack.
// Optional misaligned-store exception (AdES) enabled by defining SU_ALIGN_CHECK_EN.
module store_unit
  import su_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_exc,
  output logic [4:0]    st_exccode,
  output logic          bus_req,
  input  logic          bus_ack,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_be,
  output logic          sq_empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = (AW - 2) + 4 + 32;

  st_fmt_t       fmt_s;
  logic          legal_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  // Formatting of the presented store; reserved types are accepted but never queued.
  always_comb begin
    fmt_s   = format_store(st_type, st_addr[1:0], st_data);
    legal_s = (st_type_e'(st_type) != ST_RSV);
    entry_s = {st_addr[AW-1:2], fmt_s.be, fmt_s.wdata};
  end

  assign accept_s = st_valid && !full_s;
  assign pop_s    = !empty_s && bus_ack;

`ifdef SU_ALIGN_CHECK_EN
  logic       misalign_s;
  logic       exc_r;
  logic [4:0] exccode_r;

  // Misalignment: SW needs a word address, SH a halfword address.
  always_comb begin
    case (st_type_e'(st_type))
      ST_SW:   misalign_s = (st_addr[1:0] != 2'b00);
      ST_SH:   misalign_s = st_addr[0];
      default: misalign_s = 1'b0;
    endcase
  end

  assign push_s = accept_s && legal_s && !misalign_s;

  // One-cycle AdES pulse following acceptance of a misaligned store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exc_r     <= 1'b0;
      exccode_r <= 5'd0;
    end else begin
      exc_r     <= accept_s && misalign_s;
      exccode_r <= (accept_s && misalign_s) ? EXC_ADES : 5'd0;
    end
  end

  assign st_exc     = exc_r;
  assign st_exccode = exccode_r;
`else
  assign push_s     = accept_s && legal_s;
  assign st_exc     = 1'b0;
  assign st_exccode = 5'd0;
`endif

  su_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign st_ready  = !full_s;
  assign sq_empty  = (count_s == {CW{1'b0}});
  assign bus_req   = !empty_s;
  assign bus_addr  = empty_s ? {AW{1'b0}} : {head_s[EW-1:36], 2'b00};
  assign bus_be    = empty_s ? 4'b0000 : head_s[35:32];
  assign bus_wdata = empty_s ? 32'h0000_0000 : head_s[31:0];

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus random traffic scored
// against a byte-addressed memory model. Define SU_ALIGN_CHECK_EN to match the DUT build.
module tb_store_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          st_valid;
  logic          st_ready;
  logic [1:0]    st_type;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_exc;
  logic [4:0]    st_exccode;
  logic          bus_req;
  logic          bus_ack;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          sq_empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_mem [int unsigned];
  logic [7:0] dut_mem [int unsigned];

  store_unit #(.DEPTH(2), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_type    (st_type),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_exc     (st_exc),
    .st_exccode (st_exccode),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .sq_empty   (sq_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    st_type  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    bus_ack  = 1'b0;
  endtask

  task automatic drive_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
    step();
    st_valid = 1'b0;
  endtask

  // Reference: which memory bytes a store writes, derived from the store rules.
  task automatic model_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                             output bit misaligned);
    int unsigned base;
    misaligned = 1'b0;
    base = a & 32'hFFFF_FFFC;
    case (t)
      2'b00: begin
`ifdef SU_ALIGN_CHECK_EN
        misaligned = (a % 4 != 0);
`endif
        if (!misaligned) for (int i = 0; i < 4; i++) mdl_mem[base + i] = d[8*i +: 8];
      end
      2'b01: begin
`ifdef SU_ALIGN_CHECK_EN
        misaligned = (a % 2 != 0);
`endif
        if (!misaligned) begin
          base = base + (((a % 4) >= 2) ? 2 : 0);
          mdl_mem[base]     = d[7:0];
          mdl_mem[base + 1] = d[15:8];
        end
      end
      2'b10: mdl_mem[a] = d[7:0];
      default: ;
    endcase
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    for (int i = 0; i < 4; i++) if (be[i]) dut_mem[a + i] = wd[8*i +: 8];
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    step();
    step();
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready actual=%0b required=1", st_ready); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req actual=%0b required=0", bus_req); end
    checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL reset_sq_empty actual=%0b required=1", sq_empty); end
    checks++; if ({st_exc, st_exccode} !== 6'd0) begin errors++; $display("FAIL reset_exc actual=%0b/%0d required=0/0", st_exc, st_exccode); end
    checks++; if ({bus_addr, bus_wdata, bus_be} !== 68'd0) begin errors++; $display("FAIL reset_bus_outs actual=%h/%h/%b required=0", bus_addr, bus_wdata, bus_be); end
    reset_n = 1'b1;
    step();
    drive_store(2'b00, 32'h100, 32'h1111_1111);
    drive_store(2'b00, 32'h104, 32'h2222_2222);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_fill_full actual=%0b required=0", st_ready); end
    bus_ack = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus_req, sq_empty, st_ready} !== 3'b011) begin errors++; $display("FAIL reset_mid_drain req/empty/ready actual=%b required=011", {bus_req, sq_empty, st_ready}); end
    bus_ack = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_entries_dropped actual=%0b required=0", bus_req); end
  endtask

  task automatic test_sb();
    drive_store(2'b10, 32'h1003, 32'h0000_00AB);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL sb_bus_req actual=%0b required=1", bus_req); end
    checks++; if (bus_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr actual=%h required=00001000", bus_addr); end
    checks++; if (bus_be !== 4'b1000) begin errors++; $display("FAIL sb_be actual=%b required=1000", bus_be); end
    checks++; if (bus_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata actual=%h required=abababab", bus_wdata); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL sb_drained actual=%0b required=1", sq_empty); end
  endtask

  task automatic test_backpressure();
    drive_store(2'b01, 32'h2002, 32'h0000_1234);
    drive_store(2'b00, 32'h2004, 32'hDEAD_BEEF);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full actual=%0b required=0", st_ready); end
    checks++; if ({bus_addr, bus_be, bus_wdata} !== {32'h2000, 4'b1100, 32'h1234_1234}) begin errors++; $display("FAIL bp_first_head actual=%h/%b/%h required=00002000/1100/12341234", bus_addr, bus_be, bus_wdata); end
    bus_ack = 1'b1;
    step();
    checks++; if ({bus_addr, bus_be, bus_wdata} !== {32'h2004, 4'b1111, 32'hDEAD_BEEF}) begin errors++; $display("FAIL bp_second_head actual=%h/%b/%h required=00002004/1111/deadbeef", bus_addr, bus_be, bus_wdata); end
    checks++; if ({st_ready, sq_empty} !== 2'b10) begin errors++; $display("FAIL bp_after_pop ready/empty actual=%b required=10", {st_ready, sq_empty}); end
    step();
    bus_ack = 1'b0;
    checks++; if ({sq_empty, bus_req, bus_be} !== 6'b100000) begin errors++; $display("FAIL bp_drained empty/req/be actual=%b required=100000", {sq_empty, bus_req, bus_be}); end
  endtask

  task automatic test_full_same_cycle();
    drive_store(2'b00, 32'h4000, 32'hAAAA_0001);
    drive_store(2'b00, 32'h4004, 32'hBBBB_0002);
    st_valid = 1'b1;
    st_type  = 2'b00;
    st_addr  = 32'h4008;
    st_data  = 32'hCCCC_0003;
    bus_ack  = 1'b1;
    step();
    checks++; if ({st_ready, bus_addr, bus_wdata} !== {1'b1, 32'h4004, 32'hBBBB_0002}) begin errors++; $display("FAIL full_nopush ready/addr/data actual=%b/%h/%h required=1/00004004/bbbb0002", st_ready, bus_addr, bus_wdata); end
    bus_ack = 1'b0;
    step();
    st_valid = 1'b0;
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_push_next actual=%0b required=0", st_ready); end
    bus_ack = 1'b1;
    step();
    checks++; if ({bus_addr, bus_wdata} !== {32'h4008, 32'hCCCC_0003}) begin errors++; $display("FAIL full_order actual=%h/%h required=00004008/cccc0003", bus_addr, bus_wdata); end
    step();
    bus_ack = 1'b0;
    checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL full_drained actual=%0b required=1", sq_empty); end
  endtask

  task automatic test_align();
    drive_store(2'b00, 32'h3001, 32'h0000_0055);
`ifdef SU_ALIGN_CHECK_EN
    checks++; if ({st_exc, st_exccode} !== {1'b1, 5'd5}) begin errors++; $display("FAIL align_exc actual=%0b/%0d required=1/5", st_exc, st_exccode); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL align_not_queued actual=%0b required=0", bus_req); end
    step();
    checks++; if ({st_exc, st_exccode} !== 6'd0) begin errors++; $display("FAIL align_pulse_width actual=%0b/%0d required=0/0", st_exc, st_exccode); end
`else
    checks++; if ({bus_addr, bus_be, bus_wdata} !== {32'h3000, 4'b1111, 32'h0000_0055}) begin errors++; $display("FAIL align_off_head actual=%h/%b/%h required=00003000/1111/00000055", bus_addr, bus_be, bus_wdata); end
    checks++; if ({st_exc, st_exccode} !== 6'd0) begin errors++; $display("FAIL align_off_exc actual=%0b/%0d required=0/0", st_exc, st_exccode); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
`endif
  endtask

  task automatic test_random();
    bit exc_pend = 1'b0;
    bit mis;
    int cyc;
    mdl_mem.delete();
    dut_mem.delete();
    for (int n = 0; n < 400; n++) begin
      checks++; if (st_exc !== exc_pend) begin errors++; $display("FAIL rand_exc cycle=%0d actual=%0b required=%0b", n, st_exc, exc_pend); end
      bus_ack = ($urandom_range(0, 2) != 0);
      if (bus_req && bus_ack) bus_write(bus_addr, bus_be, bus_wdata);
      st_valid = ($urandom_range(0, 3) != 0);
      st_type  = 2'($urandom_range(0, 3));
      st_addr  = 32'h8000 + $urandom_range(0, 15);
      st_data  = $urandom;
      exc_pend = 1'b0;
      if (st_valid && st_ready) begin
        model_store(st_type, st_addr, st_data, mis);
        exc_pend = mis;
      end
      step();
    end
    st_valid = 1'b0;
    checks++; if (st_exc !== exc_pend) begin errors++; $display("FAIL rand_exc_last actual=%0b required=%0b", st_exc, exc_pend); end
    cyc = 0;
    while (!sq_empty && cyc < 50) begin
      bus_ack = 1'b1;
      if (bus_req) bus_write(bus_addr, bus_be, bus_wdata);
      step();
      cyc++;
    end
    bus_ack = 1'b0;
    checks++; if (sq_empty !== 1'b1) begin errors++; $display("FAIL rand_drain_timeout actual=%0b required=1", sq_empty); end
    checks++; if (dut_mem.num() !== mdl_mem.num()) begin errors++; $display("FAIL rand_bytes_written actual=%0d required=%0d", dut_mem.num(), mdl_mem.num()); end
    foreach (mdl_mem[a]) begin
      checks++;
      if (!dut_mem.exists(a)) begin
        errors++; $display("FAIL rand_mem addr=%h actual=unwritten required=%h", a, mdl_mem[a]);
      end else if (dut_mem[a] !== mdl_mem[a]) begin
        errors++; $display("FAIL rand_mem addr=%h actual=%h required=%h", a, dut_mem[a], mdl_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_backpressure();
    test_full_same_cycle();
    test_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
